// File: rtl/fft_128_mem_seq.sv
// In-place 128-point radix-2 FFT working memory and address sequencer.
// Loads bit-reversed, issues per-stage A/B operand reads, writes results back PIPE_LAT later, unloads in natural order.
module fft_128_mem_seq #(
    parameter int DW       = 32,
    parameter int PIPE_LAT = 3,
    parameter int N_LOG2   = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_is_a,
    output logic [5:0]    tw_addr,
    output logic [2:0]    stage,
    output logic          out_valid,
    output logic          busy,
    output logic          done
);

    localparam int AW = N_LOG2;
    localparam int N  = 1 << AW;
    localparam logic [AW:0] CNT_LAST  = (AW+1)'(N - 1);
    localparam logic [AW:0] CNT_N     = (AW+1)'(N);
    localparam logic [AW:0] DRAIN_END = (AW+1)'(PIPE_LAT);
    localparam logic [2:0]  S_LAST    = 3'(N_LOG2 - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, UNLOAD, FIN} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [2:0]        s_q, s_d;
    logic [DW-1:0]     mem [N];
    logic [DW-1:0]     rd_data_q;
    logic              rd_valid_q, rd_is_a_q, out_valid_q;
    logic [5:0]        tw_addr_q;
    logic [AW-1:0]     dl_addr_q [PIPE_LAT];
    logic [PIPE_LAT-1:0] dl_v_q;

    logic [AW-1:0] k7, span, mask, a_addr, b_addr, rd_addr, wr_addr;
    logic [5:0]    tw;
    logic          issue_calc, issue_a, issue_out, rd_en, wr_en;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int unsigned i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    // CALC counter packs {k, p}: k = butterfly index, p = 0 for A, 1 for B
    always_comb begin
        k7         = {1'b0, cnt_q[AW-1:1]};
        span       = AW'(1) << s_q;
        mask       = span - AW'(1);
        a_addr     = ((k7 >> s_q) << (s_q + 3'd1)) | (k7 & mask);
        b_addr     = a_addr | span;
        tw         = 6'((k7 & mask) << (3'd6 - s_q));
        issue_calc = (state_q == CALC);
        issue_a    = issue_calc & ~cnt_q[0];
        issue_out  = (state_q == UNLOAD) & ~cnt_q[AW];
        rd_en      = issue_calc | issue_out;
        rd_addr    = issue_calc ? (cnt_q[0] ? b_addr : a_addr) : cnt_q[AW-1:0];
        if (state_q == LOAD) begin
            wr_en   = 1'b1;
            wr_addr = bitrev(cnt_q[AW-1:0]);
        end else begin
            wr_en   = dl_v_q[PIPE_LAT-1];
            wr_addr = dl_addr_q[PIPE_LAT-1];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        s_d     = s_q;
        busy    = (state_q == LOAD) || (state_q == CALC) ||
                  (state_q == DRAIN) || (state_q == UNLOAD);
        done    = (state_q == FIN);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = LOAD;
                    s_d     = '0;
                end
            end
            LOAD: if (cnt_q == CNT_LAST) begin
                state_d = CALC;
                cnt_d   = '0;
            end
            CALC: if (cnt_q == CNT_LAST) begin
                state_d = DRAIN;
                cnt_d   = '0;
            end
            DRAIN: if (cnt_q == DRAIN_END) begin
                cnt_d = '0;
                if (s_q == S_LAST) begin
                    state_d = UNLOAD;
                end else begin
                    state_d = CALC;
                    s_d     = s_q + 3'd1;
                end
            end
            // one extra cycle after the last read so its out_valid is seen before FIN
            UNLOAD: if (cnt_q == CNT_N) begin
                state_d = FIN;
                cnt_d   = '0;
            end
            FIN: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            s_q         <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_is_a_q   <= 1'b0;
            out_valid_q <= 1'b0;
            tw_addr_q   <= '0;
            dl_v_q      <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) dl_addr_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            if (rd_en) rd_data_q <= mem[rd_addr];
            rd_valid_q  <= issue_calc;
            rd_is_a_q   <= issue_a;
            out_valid_q <= issue_out;
            tw_addr_q   <= issue_a ? tw : (issue_calc ? tw_addr_q : '0);
            dl_v_q      <= {dl_v_q[PIPE_LAT-2:0], issue_calc};
            dl_addr_q[0] <= rd_addr;
            for (int unsigned i = 1; i < PIPE_LAT; i++) dl_addr_q[i] <= dl_addr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_is_a   = rd_is_a_q;
    assign tw_addr   = tw_addr_q;
    assign stage     = s_q;
    assign out_valid = out_valid_q;

endmodule
